// File: rtl/seq_det_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_det_prog                                               |
// | Description : Runtime-programmable serial bit-pattern detector with      |
// |               Mealy/Moore match pulses and a saturating match counter.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_det_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(4'b1010),
  parameter logic [LEN_W-1:0]   RST_LEN     = LEN_W'(4),
  parameter logic               RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic               z_q,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_z_q;
  logic [CNT_W-1:0]   r_cnt;

  logic [LEN_W-1:0]   w_eff_len;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic               w_z;

  assign w_eff_len = (r_len > c_max_len) ? c_max_len : r_len;

  // Candidate window: stored history with the current bit appended as the newest (bit 0).
  assign w_window = {r_hist[MAX_LEN-2:0], x};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < w_eff_len);
    end
  end

  assign w_hit = (((w_window ^ r_pattern) & w_mask) == '0);

  // fill gate guarantees every compared bit arrived after the last flush.
  assign w_z = en & ~cfg_load & (w_eff_len != '0)
             & (r_fill >= (w_eff_len - LEN_W'(1))) & w_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pattern <= RST_PATTERN;
      r_len     <= RST_LEN;
      r_overlap <= RST_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_z_q     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_z_q <= w_z;

      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_z && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (cfg_load) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (en) begin
        r_hist <= w_window;
        // Non-overlap restarts the fresh-bit count so the next match needs L new bits.
        if (w_z && !r_overlap) begin
          r_fill <= '0;
        end else if (r_fill < w_eff_len) begin
          r_fill <= r_fill + LEN_W'(1);
        end else begin
          r_fill <= w_eff_len;
        end
      end
    end
  end

  assign z         = w_z;
  assign z_q       = r_z_q;
  assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seq_det_prog                                            |
// | Description : Self-checking bench for seq_det_prog against a stream model|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seq_det_prog;

  logic       clk = 1'b0;
  logic       rst_n, en, x, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       z, z_q, z2, z_q2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  always #5 clk = ~clk;

  seq_det_prog dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .z_q(z_q), .match_cnt(match_cnt)
  );

  seq_det_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z2), .z_q(z_q2), .match_cnt(match_cnt2)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the raw stream since the last flush plus a count of fresh bits.
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ovl;
  logic       m_bits[$];
  int         m_avail;
  logic       m_zq;
  int         m_cnt, m_cnt2;

  logic       exp_z, obs_z, z_chk, obs_zq;
  logic [7:0] obs_cnt;
  logic [1:0] obs_cnt2;

  function automatic logic model_z();
    int l;
    logic b;
    if (!rst_n || cfg_load || !en) return 1'b0;
    l = (m_len > 8) ? 8 : m_len;
    if (l == 0) return 1'b0;
    if (m_avail + 1 < l) return 1'b0;
    for (int k = 0; k < l; k++) begin
      b = (k == 0) ? x : m_bits[m_bits.size() - k];
      if (b != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_pat = 8'b1010; m_len = 4; m_ovl = 1'b1;
      m_bits.delete(); m_avail = 0; m_zq = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_zq = exp_z;
      if (cnt_clr) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (exp_z) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
      if (cfg_load) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
        m_bits.delete(); m_avail = 0;
      end else if (en) begin
        m_bits.push_back(x);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        if (exp_z && !m_ovl) m_avail = 0;
        else if (m_avail < 64) m_avail++;
      end
    end
  endtask

  // One clock of stimulus: samples the Mealy output before the edge and state after it.
  task automatic drive(input logic r_n, input logic e, input logic xb,
                       input logic ld, input logic cl);
    rst_n = r_n; en = e; x = xb; cfg_load = ld; cnt_clr = cl;
    #2;
    exp_z = model_z();
    obs_z = z;
    z_chk = r_n;
    @(posedge clk);
    model_update();
    #1;
    obs_zq = z_q; obs_cnt = match_cnt; obs_cnt2 = match_cnt2;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_zq !== 1'b0 || obs_cnt !== 8'd0 || obs_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got zq=%b cnt=%0d cnt2=%0d exp zq=0 cnt=0 cnt2=0", obs_zq, obs_cnt, obs_cnt2);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_z !== 1'b0) begin
      failures++;
      $display("FAIL reset_z got=%b exp=0", obs_z);
    end
  endtask

  task automatic test_overlap_default();
    logic [5:0] seq = 6'b101010;
    logic [5:0] hits = '0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, seq[5-i], 1'b0, 1'b0);
      hits[i] = obs_z;
      checks++;
      if (obs_z !== exp_z || obs_zq !== m_zq || obs_cnt !== 8'(m_cnt)) begin
        failures++;
        $display("FAIL t1_step%0d got z=%b zq=%b cnt=%0d exp z=%b zq=%b cnt=%0d", i, obs_z, obs_zq, obs_cnt, exp_z, m_zq, m_cnt);
      end
    end
    checks++;
    if (hits !== 6'b101000 || obs_cnt !== 8'd2) begin
      failures++;
      $display("FAIL t1_summary got hits=%b cnt=%0d exp hits=101000 cnt=2", hits, obs_cnt);
    end
  endtask

  task automatic test_non_overlap();
    logic [7:0] seq = 8'b10101010;
    logic [7:0] hits = '0;
    do_reset();
    load_cfg(8'b1010, 4'd4, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, seq[7-i], 1'b0, 1'b0);
      hits[i] = obs_z;
      checks++;
      if (obs_z !== exp_z || obs_zq !== m_zq || obs_cnt !== 8'(m_cnt)) begin
        failures++;
        $display("FAIL t2_step%0d got z=%b zq=%b cnt=%0d exp z=%b zq=%b cnt=%0d", i, obs_z, obs_zq, obs_cnt, exp_z, m_zq, m_cnt);
      end
    end
    checks++;
    if (hits !== 8'b10001000 || obs_cnt !== 8'd2) begin
      failures++;
      $display("FAIL t2_summary got hits=%b cnt=%0d exp hits=10001000 cnt=2", hits, obs_cnt);
    end
  endtask

  task automatic test_ones_modes();
    logic [6:0] hits;
    logic [6:0] want;
    for (int m = 0; m < 2; m++) begin
      hits = '0;
      want = (m == 0) ? 7'b0100100 : 7'b1111100;
      do_reset();
      load_cfg(8'b111, 4'd3, m[0]);
      for (int i = 0; i < 7; i++) begin
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        hits[i] = obs_z;
        checks++;
        if (obs_z !== exp_z || obs_zq !== m_zq) begin
          failures++;
          $display("FAIL t3_ovl%0d_step%0d got z=%b zq=%b exp z=%b zq=%b", m, i, obs_z, obs_zq, exp_z, m_zq);
        end
      end
      checks++;
      if (hits !== want) begin
        failures++;
        $display("FAIL t3_ovl%0d_hits got=%b exp=%b", m, hits, want);
      end
    end
  endtask

  task automatic test_en_gap();
    logic [6:0] ens = 7'b1100011;
    logic [6:0] xs  = 7'b1000010;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ens[6-i], xs[6-i], 1'b0, 1'b0);
      checks++;
      if (obs_z !== exp_z || obs_zq !== m_zq || (!ens[6-i] && obs_zq !== 1'b0)) begin
        failures++;
        $display("FAIL t4_step%0d got z=%b zq=%b exp z=%b zq=%b", i, obs_z, obs_zq, exp_z, m_zq);
      end
    end
    checks++;
    if (obs_z !== 1'b1 || obs_cnt !== 8'd1) begin
      failures++;
      $display("FAIL t4_final got z=%b cnt=%0d exp z=1 cnt=1", obs_z, obs_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] seq = 3'b101;
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, seq[2-i], 1'b0, 1'b0);
    do_reset();
    checks++;
    if (obs_zq !== 1'b0 || obs_cnt !== 8'd0) begin
      failures++;
      $display("FAIL t5_after_reset got zq=%b cnt=%0d exp zq=0 cnt=0", obs_zq, obs_cnt);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_z !== 1'b0 || exp_z !== 1'b0) begin
      failures++;
      $display("FAIL t5_no_match got z=%b model=%b exp=0", obs_z, exp_z);
    end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, ~i[0], 1'b0, 1'b0);
      checks++;
      if (obs_z !== exp_z || obs_cnt !== 8'(m_cnt) || obs_cnt2 !== 2'(m_cnt2)) begin
        failures++;
        $display("FAIL t6_step%0d got z=%b cnt=%0d cnt2=%0d exp z=%b cnt=%0d cnt2=%0d", i, obs_z, obs_cnt, obs_cnt2, exp_z, m_cnt, m_cnt2);
      end
    end
    checks++;
    if (obs_cnt !== 8'd5 || obs_cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL t6_saturate got cnt=%0d cnt2=%0d exp cnt=5 cnt2=3", obs_cnt, obs_cnt2);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_z !== 1'b1 || obs_zq !== 1'b1 || obs_cnt !== 8'd0 || obs_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL t6_clear got z=%b zq=%b cnt=%0d cnt2=%0d exp z=1 zq=1 cnt=0 cnt2=0", obs_z, obs_zq, obs_cnt, obs_cnt2);
    end
  endtask

  task automatic test_len_bounds();
    logic [7:0] seq = 8'b10100101;
    do_reset();
    load_cfg(8'h00, 4'd0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checks++;
      if (obs_z !== 1'b0 || exp_z !== 1'b0) begin
        failures++;
        $display("FAIL t7_len0_step%0d got z=%b model=%b exp=0", i, obs_z, exp_z);
      end
    end
    for (int n = 0; n < 2; n++) begin
      load_cfg(8'hA5, (n == 0) ? 4'd8 : 4'd13, 1'b1);
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 1'b1, seq[7-i], 1'b0, 1'b0);
        checks++;
        if (obs_z !== exp_z || obs_z !== (i == 7)) begin
          failures++;
          $display("FAIL t7_full%0d_step%0d got z=%b model=%b", n, i, obs_z, exp_z);
        end
      end
    end
    checks++;
    if (obs_cnt !== 8'd2) begin
      failures++;
      $display("FAIL t7_count got cnt=%0d exp=2", obs_cnt);
    end
  endtask

  task automatic test_random();
    logic       ld;
    logic [3:0] l;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      ld = ($urandom_range(0, 39) == 0);
      if (ld) begin
        l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
        cfg_pattern = 8'($urandom);
        cfg_len     = l;
        cfg_overlap = 1'($urandom_range(0, 1));
      end
      drive(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ld, 1'($urandom_range(0, 49) == 0));
      if (z_chk) begin
        checks++;
        if (obs_z !== exp_z) begin
          failures++;
          $display("FAIL rand_z cyc=%0d got=%b exp=%b", i, obs_z, exp_z);
        end
      end
      checks++;
      if (obs_zq !== m_zq || obs_cnt !== 8'(m_cnt) || obs_cnt2 !== 2'(m_cnt2)) begin
        failures++;
        $display("FAIL rand_state cyc=%0d got zq=%b cnt=%0d cnt2=%0d exp zq=%b cnt=%0d cnt2=%0d", i, obs_zq, obs_cnt, obs_cnt2, m_zq, m_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; x = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    test_reset();
    test_overlap_default();
    test_non_overlap();
    test_ones_modes();
    test_en_gap();
    test_mid_reset();
    test_saturate_clear();
    test_len_bounds();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
